// File: rtl/trig_scheduler_if.sv
// Trigger request/grant bundle between the requesters and trig_scheduler.
// The scheduler uses the slave modport. The requester side or the bench uses the master modport.
interface trig_scheduler_if #(
    parameter int SRC_W = 2
);
    localparam int NSRC = 2 ** SRC_W;

    logic             in_live;
    logic [NSRC-1:0]  req;
    logic             trig_out;
    logic [SRC_W-1:0] trig_src;
    logic             busy;
    logic [NSRC-1:0]  pend;

    modport master (
        output in_live, req,
        input  trig_out, trig_src, busy, pend
    );

    modport slave (
        input  in_live, req,
        output trig_out, trig_src, busy, pend
    );
endinterface

// File: rtl/trig_scheduler.sv
// Shares one trigger output among NSRC requesters, using fixed or round-robin priority and a programmable dead time.
// Optional: define TRIG_SCHED_VETO_EN to add the veto input and the veto_cnt output.
module trig_scheduler #(
    parameter int SRC_W = 2,
    parameter int GAP_W = 20,
    parameter int CNT_W = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    trig_scheduler_if.slave         bus,
    input  logic [(2**SRC_W)-1:0]   user_ena,
    input  logic                    user_rr,
    input  logic [GAP_W-1:0]        user_deadtime,
    input  logic                    cnt_clr,
    input  logic [SRC_W-1:0]        cnt_sel,
`ifdef TRIG_SCHED_VETO_EN
    input  logic                    veto,
    output logic [CNT_W-1:0]        veto_cnt,
`endif
    output logic [CNT_W-1:0]        acc_cnt,
    output logic [CNT_W-1:0]        lost_cnt
);
    localparam int NSRC = 2 ** SRC_W;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_DEAD = 1'b1
    } state_t;

    state_t           state_r;
    logic [GAP_W-1:0] dcnt_r;
    logic [SRC_W-1:0] rr_ptr_r;
    logic             trig_out_r;
    logic [SRC_W-1:0] trig_src_r;
    logic             busy_r;
    logic [NSRC-1:0]  pend_r;
    logic [CNT_W-1:0] acc_r  [NSRC];
    logic [CNT_W-1:0] lost_r [NSRC];

    logic [NSRC-1:0]  elig_s;
    logic [NSRC-1:0]  set_s;
    logic [NSRC-1:0]  grant_vec_s;
    logic [NSRC-1:0]  lost_inc_s;
    logic [NSRC-1:0]  pend_nxt_s;
    logic [SRC_W-1:0] winner_s;
    logic             grant_s;
    logic             veto_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (v == {CNT_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + CNT_W'(1);
        end
        return r;
    endfunction

    function automatic logic [SRC_W-1:0] pick_fixed(input logic [NSRC-1:0] v);
        logic [SRC_W-1:0] w;
        w = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (v[i]) begin
                w = SRC_W'(i);
            end else begin
                w = w;
            end
        end
        return w;
    endfunction

    // Search starts just above the last winner and wraps naturally through the SRC_W-bit index.
    function automatic logic [SRC_W-1:0] pick_rr(input logic [NSRC-1:0] v,
                                                 input logic [SRC_W-1:0] ptr);
        logic [SRC_W-1:0] w;
        logic [SRC_W-1:0] idx;
        logic             found;
        w     = '0;
        found = 1'b0;
        for (int k = 1; k <= NSRC; k++) begin
            idx = ptr + SRC_W'(k);
            if (!found && v[idx]) begin
                w     = idx;
                found = 1'b1;
            end else begin
                w     = w;
                found = found;
            end
        end
        return w;
    endfunction

`ifdef TRIG_SCHED_VETO_EN
    assign veto_s = veto;
`else
    assign veto_s = 1'b0;
`endif

    // Arbitration: eligibility, the winner, and the grant decision.
    always_comb begin
        elig_s   = pend_r & user_ena;
        winner_s = user_rr ? pick_rr(elig_s, rr_ptr_r) : pick_fixed(elig_s);
        grant_s  = (state_r == ST_IDLE) && bus.in_live && (elig_s != '0) && !veto_s;
        for (int i = 0; i < NSRC; i++) begin
            grant_vec_s[i] = grant_s && (winner_s == SRC_W'(i));
        end
    end

    // Pending-latch update. A new request beats a grant of the same bit.
    always_comb begin
        set_s      = bus.req & user_ena & {NSRC{bus.in_live}};
        lost_inc_s = set_s & pend_r & ~grant_vec_s;
        if (bus.in_live) begin
            pend_nxt_s = (set_s | (pend_r & ~grant_vec_s)) & user_ena;
        end else begin
            pend_nxt_s = '0;
        end
    end

    // Scheduler FSM, including the dead-time counter and the registered trigger outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            dcnt_r     <= '0;
            rr_ptr_r   <= '0;
            trig_out_r <= 1'b0;
            trig_src_r <= '0;
            busy_r     <= 1'b0;
            pend_r     <= '0;
        end else if (!bus.in_live) begin
            state_r    <= ST_IDLE;
            dcnt_r     <= '0;
            trig_out_r <= 1'b0;
            busy_r     <= 1'b0;
            pend_r     <= '0;
        end else begin
            pend_r <= pend_nxt_s;
            case (state_r)
                ST_IDLE: begin
                    if (grant_s) begin
                        trig_out_r <= 1'b1;
                        trig_src_r <= winner_s;
                        rr_ptr_r   <= winner_s;
                        dcnt_r     <= user_deadtime;
                        state_r    <= ST_DEAD;
                        busy_r     <= 1'b1;
                    end else begin
                        trig_out_r <= 1'b0;
                        busy_r     <= 1'b0;
                    end
                end
                ST_DEAD: begin
                    trig_out_r <= 1'b0;
                    if (dcnt_r == '0) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        dcnt_r  <= dcnt_r - GAP_W'(1);
                        busy_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    trig_out_r <= 1'b0;
                    busy_r     <= 1'b0;
                end
            endcase
        end
    end

    // Per-source accepted and lost counters. They saturate, and a clear takes priority over an increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NSRC; i++) begin
                acc_r[i]  <= '0;
                lost_r[i] <= '0;
            end
        end else if (cnt_clr) begin
            for (int i = 0; i < NSRC; i++) begin
                acc_r[i]  <= '0;
                lost_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NSRC; i++) begin
                if (grant_vec_s[i]) begin
                    acc_r[i] <= sat_inc(acc_r[i]);
                end else begin
                    acc_r[i] <= acc_r[i];
                end
                if (lost_inc_s[i]) begin
                    lost_r[i] <= sat_inc(lost_r[i]);
                end else begin
                    lost_r[i] <= lost_r[i];
                end
            end
        end
    end

`ifdef TRIG_SCHED_VETO_EN
    logic [CNT_W-1:0] veto_cnt_r;

    // Count the IDLE cycles in which a ready grant was held off by veto.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            veto_cnt_r <= '0;
        end else if (cnt_clr) begin
            veto_cnt_r <= '0;
        end else if (veto && bus.in_live && (elig_s != '0) && (state_r == ST_IDLE)) begin
            veto_cnt_r <= sat_inc(veto_cnt_r);
        end else begin
            veto_cnt_r <= veto_cnt_r;
        end
    end

    assign veto_cnt = veto_cnt_r;
`endif

    assign bus.trig_out = trig_out_r;
    assign bus.trig_src = trig_src_r;
    assign bus.busy     = busy_r;
    assign bus.pend     = pend_r;
    assign acc_cnt      = acc_r[cnt_sel];
    assign lost_cnt     = lost_r[cnt_sel];
endmodule

// File: tb/tb_trig_scheduler.sv
// Randomized bench for trig_scheduler. It checks the DUT against a cycle-count reference model.
// The counters are narrowed to 8 bits so that saturation is reached during the run.
module tb_trig_scheduler;
    localparam int SRC_W = 2;
    localparam int NSRC  = 4;
    localparam int GAP_W = 20;
    localparam int CNT_W = 8;
    localparam int CMAX  = 255;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    trig_scheduler_if #(.SRC_W(SRC_W)) bus ();

    logic [NSRC-1:0]  user_ena = '0;
    logic             user_rr = 1'b0;
    logic [GAP_W-1:0] user_deadtime = '0;
    logic             cnt_clr = 1'b0;
    logic [SRC_W-1:0] cnt_sel = '0;
    logic [CNT_W-1:0] acc_cnt;
    logic [CNT_W-1:0] lost_cnt;
`ifdef TRIG_SCHED_VETO_EN
    logic             veto = 1'b0;
    logic [CNT_W-1:0] veto_cnt;
`endif

    trig_scheduler #(.SRC_W(SRC_W), .GAP_W(GAP_W), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus),
        .user_ena      (user_ena),
        .user_rr       (user_rr),
        .user_deadtime (user_deadtime),
        .cnt_clr       (cnt_clr),
        .cnt_sel       (cnt_sel),
`ifdef TRIG_SCHED_VETO_EN
        .veto          (veto),
        .veto_cnt      (veto_cnt),
`endif
        .acc_cnt       (acc_cnt),
        .lost_cnt      (lost_cnt)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        if (obs !== want) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, obs, want, $time);
        end
    endtask

    // Reference model state. Dead time is tracked as the earliest edge at which the next grant is allowed.
    logic [NSRC-1:0] m_pend = '0;
    int  m_acc [NSRC];
    int  m_lost[NSRC];
    int  m_vcnt = 0;
    int  m_ptr = 0;
    int  m_src = 0;
    bit  m_trig = 1'b0;
    bit  m_busy = 1'b0;
    int  next_ok = 0;
    int  cyc = 0;

    function automatic int sat(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    task automatic step(input bit live, input logic [NSRC-1:0] rq, input logic [NSRC-1:0] en,
                        input bit rr, input int dt, input bit clr, input int sel, input bit vt);
        bit              any;
        bit              gnt;
        bit              vt_eff;
        bit              gi;
        int              w;
        int              idx;
        logic [NSRC-1:0] elig;
        logic [NSRC-1:0] np;
        @(negedge clk);
        bus.in_live   = live;
        bus.req       = rq;
        user_ena      = en;
        user_rr       = rr;
        user_deadtime = GAP_W'(dt);
        cnt_clr       = clr;
        cnt_sel       = SRC_W'(sel);
`ifdef TRIG_SCHED_VETO_EN
        veto          = vt;
        vt_eff        = vt;
`else
        vt_eff        = 1'b0;
`endif
        @(posedge clk);
        cyc++;
        elig = m_pend & en;
        any  = (elig != '0);
        if (vt_eff && live && any && !m_busy) m_vcnt = sat(m_vcnt);
        gnt = live && !vt_eff && any && (cyc >= next_ok);
        w = 0;
        if (!rr) begin
            for (int i = NSRC - 1; i >= 0; i--) if (elig[i]) w = i;
        end else begin
            for (int k = NSRC; k >= 1; k--) begin
                idx = (m_ptr + k) % NSRC;
                if (elig[idx]) w = idx;
            end
        end
        m_trig = gnt;
        if (gnt) begin
            m_src   = w;
            m_ptr   = w;
            m_acc[w] = sat(m_acc[w]);
            next_ok = cyc + dt + 2;
        end
        for (int i = 0; i < NSRC; i++) begin
            gi = gnt && (w == i);
            if (!live || !en[i]) begin
                np[i] = 1'b0;
            end else if (rq[i]) begin
                if (m_pend[i] && !gi) m_lost[i] = sat(m_lost[i]);
                np[i] = 1'b1;
            end else begin
                np[i] = m_pend[i] && !gi;
            end
        end
        m_pend = np;
        if (!live) next_ok = 0;
        m_busy = live && (cyc < next_ok - 1);
        if (clr) begin
            for (int i = 0; i < NSRC; i++) begin
                m_acc[i]  = 0;
                m_lost[i] = 0;
            end
            m_vcnt = 0;
        end
        #1;
        check_eq("trig_out", 32'(bus.trig_out), 32'(m_trig));
        check_eq("trig_src", 32'(bus.trig_src), 32'(m_src));
        check_eq("busy",     32'(bus.busy),     32'(m_busy));
        check_eq("pend",     32'(bus.pend),     32'(m_pend));
        check_eq("acc_cnt",  32'(acc_cnt),      32'(m_acc[sel]));
        check_eq("lost_cnt", 32'(lost_cnt),     32'(m_lost[sel]));
`ifdef TRIG_SCHED_VETO_EN
        check_eq("veto_cnt", 32'(veto_cnt),     32'(m_vcnt));
`endif
    endtask

    initial begin
        bit              cur_rr;
        int              cur_dt;
        int              dens;
        bit              vt_state;
        logic [NSRC-1:0] ena;
        logic [NSRC-1:0] rq;
        int              dt_now;

        for (int i = 0; i < NSRC; i++) begin
            m_acc[i]  = 0;
            m_lost[i] = 0;
        end
        bus.in_live = 1'b0;
        bus.req     = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_trig_out", 32'(bus.trig_out), 32'd0);
        check_eq("rst_trig_src", 32'(bus.trig_src), 32'd0);
        check_eq("rst_busy",     32'(bus.busy),     32'd0);
        check_eq("rst_pend",     32'(bus.pend),     32'd0);
        check_eq("rst_acc",      32'(acc_cnt),      32'd0);
        check_eq("rst_lost",     32'(lost_cnt),     32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Two requests collide under fixed priority with a dead time of 3.
        step(1'b1, 4'b0110, 4'hF, 1'b0, 3, 1'b0, 1, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b1, 4'b0000, 4'hF, 1'b0, 3, 1'b0, (i % 2) + 1, 1'b0);
        // A repeated request during a long dead time is counted as lost.
        step(1'b1, 4'b0001, 4'hF, 1'b0, 10, 1'b0, 0, 1'b0);
        step(1'b1, 4'b0000, 4'hF, 1'b0, 10, 1'b0, 0, 1'b0);
        step(1'b1, 4'b0001, 4'hF, 1'b0, 10, 1'b0, 0, 1'b0);
        step(1'b1, 4'b0000, 4'hF, 1'b0, 10, 1'b0, 0, 1'b0);
        step(1'b1, 4'b0001, 4'hF, 1'b0, 10, 1'b0, 0, 1'b0);
        for (int i = 0; i < 12; i++) step(1'b1, 4'b0000, 4'hF, 1'b0, 10, 1'b0, 0, 1'b0);
        // Dropping in_live mid-DEAD with a pending request flushes it.
        step(1'b1, 4'b0001, 4'hF, 1'b0, 6, 1'b0, 3, 1'b0);
        step(1'b1, 4'b1000, 4'hF, 1'b0, 6, 1'b0, 3, 1'b0);
        step(1'b0, 4'b0000, 4'hF, 1'b0, 6, 1'b0, 3, 1'b0);
        step(1'b1, 4'b0000, 4'hF, 1'b0, 6, 1'b0, 3, 1'b0);

        cur_rr   = 1'b1;
        cur_dt   = 0;
        dens     = 3;
        vt_state = 1'b0;
        ena      = 4'hF;
        for (int c = 0; c < 6000; c++) begin
            if (c % 250 == 0) begin
                cur_rr = 1'($urandom_range(0, 1));
                case ($urandom_range(0, 4))
                    0: cur_dt = 0;
                    1: cur_dt = 1;
                    2: cur_dt = 3;
                    3: cur_dt = 10;
                    default: cur_dt = int'($urandom_range(0, 6));
                endcase
            end
            if (c % 60 == 0) begin
                ena  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
                dens = int'($urandom_range(0, 3));
            end
            case (dens)
                3: rq = 4'hF;
                2: rq = 4'($urandom);
                default: rq = 4'($urandom) & 4'($urandom) & 4'($urandom);
            endcase
            if ($urandom_range(0, 19) == 0) vt_state = !vt_state;
            dt_now = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 12)) : cur_dt;
            step($urandom_range(0, 39) != 0, rq, ena, cur_rr, dt_now,
                 $urandom_range(0, 999) == 0, int'($urandom_range(0, NSRC - 1)), vt_state);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/trig_scheduler.md
Name: trig_scheduler

Overview:
Shares the single trigger output between NSRC trigger requesters, e.g. periodic clock-trigger generators, the physics trigger and calibration/LED triggers. Each requester's pulse is latched as pending. A grant is issued under fixed or round-robin priority, and a programmable dead time is enforced between issued triggers. Per-source accepted and lost counters are kept for run monitoring.

Parameters:
SRC_W, 2, source index width; NSRC = 2**SRC_W sources (localparam).
GAP_W, 20, width of dead-time register.
CNT_W, 32, width of per-source accepted/lost counters.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
in_live  input  1  live/spill gate; low = idle and flush
req  input  NSRC  per-source request pulse; a level held high counts every cycle
user_ena  input  NSRC  per-source enable
user_rr  input  1  0 = fixed priority (index 0 highest), 1 = round robin
user_deadtime  input  GAP_W  dead cycles after each issued trigger
cnt_clr  input  1  synchronous clear of all counters
cnt_sel  input  SRC_W  counter readout select
trig_out  output  1  one-cycle trigger pulse
trig_src  output  SRC_W  source index of the last issued trigger
busy  output  1  high while state is DEAD
pend  output  NSRC  pending latches
acc_cnt  output  CNT_W  accepted count of source cnt_sel (combinational mux)
lost_cnt  output  CNT_W  lost count of source cnt_sel (combinational mux)

Behaviour:
- Reset (rst_n low, async) clears everything to 0:
  - trig_out, trig_src, busy, pend, state (IDLE), dead counter dcnt, RR pointer, all counters.
- States: IDLE, DEAD. Eligible set elig = pend & user_ena.
- IDLE with in_live=1 and elig != 0, at the edge:
  - trig_out <= 1; trig_src <= winner; pend[winner] cleared.
  - acc[winner]++; dcnt <= user_deadtime; state <= DEAD; RR pointer <= winner.
- DEAD, each edge: trig_out <= 0. If dcnt == 0, state <= IDLE; else dcnt--.
- busy = (state == DEAD).
- Trigger spacing: minimum distance between trig_out pulses is user_deadtime + 2 cycles. trig_out is never high on two consecutive cycles.
- Winner selection:
  - user_rr=0: lowest set index of elig.
  - user_rr=1: first set index searching from pointer+1 upward, wrapping mod NSRC.
- Pending latch, source i:
  - pend[i] is set at an edge where req[i] & user_ena[i] & in_live.
  - If req arrives while pend[i] is already set and not being granted that cycle: pend[i] stays 1 and lost[i]++.
  - Set and grant of the same bit in one cycle: the set wins, pend[i] stays 1, not counted as lost.
- user_ena[i] low: pend[i] cleared next edge; req[i] ignored.
- in_live low (synchronous, takes priority over everything except rst_n):
  - pend <= 0; state <= IDLE; dcnt <= 0; trig_out <= 0; requests ignored.
  - Counters and trig_src are held.
  - An in_live drop mid-DEAD aborts the dead time.
- Counters saturate at all-ones; they do not wrap.
- cnt_clr: clears all acc/lost counters next edge. It overrides an increment in the same cycle.
- user_deadtime is sampled only at grant; changes during DEAD take effect on the next grant.

Optional Feature:
TRIG_SCHED_VETO_EN.
- Defined:
  - Adds input veto (1 bit, e.g. DAQ buffer full). While veto=1 in IDLE, no grant is issued; pend is preserved and still accepts new requests.
  - Adds output veto_cnt (CNT_W, saturating, cleared by cnt_clr). It counts cycles where veto & in_live & (elig != 0) & IDLE.
  - Veto does not affect DEAD countdown.
- Undefined: no veto port, no veto_cnt port; grants never blocked.

Test Plan:
- Fixed priority collision: in_live=1, ena=4'b1111, rr=0, deadtime=3, req=4'b0110 pulsed once -> trig_out at cycle+1 with src=1, second trig_out 5 cycles later with src=2; acc[1]=acc[2]=1.
- Round robin: rr=1, req held 4'b1111 for 20 cycles, deadtime=0 -> trig_src sequence 0,1,2,3,0,... one pulse every 2 cycles; lost counters increment while pend bits stay set.
- Lost request: deadtime=10, req[0] pulsed at t and t+2 -> one trigger at t+1; the t+2 pulse sets pend[0]; a further pulse at t+4 gives lost[0]=1 and a second trigger when DEAD ends.
- in_live drop mid-DEAD with pend=4'b1000 -> next edge pend=0, busy=0, no trigger; acc/lost unchanged.
- Saturation/clear: force acc[2] to all-ones, grant src 2 -> acc stays all-ones; cnt_clr=1 -> all counters 0 next cycle.
- (TRIG_SCHED_VETO_EN) veto=1 for 8 cycles with pend[3] set -> no trig_out, veto_cnt=8; veto=0 -> trig_out src=3 next edge.
